instr_encoder: RTL and testbench

- Program-load encoder: the inverse of the processor's opcode/func decode.
- Accepts one mnemonic-level instruction per handshake, packs it into the 16-bit instruction word the control unit decodes, and writes it into instruction memory at a sequential address.
- Sits between the test/boot loader and the instruction memory write port.
- Computes PC-relative branch offsets and range-checks every field.

---
 rtl/instr_encoder.sv | 178 +++++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: program-load encoder for the instruction memory.
// Takes one mnemonic-level instruction per valid/ready handshake, packs it into
// the 16-bit word the control unit decodes, and writes it at sequential addresses.
// Branch targets are converted to PC-relative offsets; every field is range-checked.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin/restart a load session (any state)
//   in_valid / in_ready   instruction handshake
//   in_mnem, in_ra/rb/rc  mnemonic and register fields
//   in_imm                immediate, or absolute target for branch/J
//   in_last               final instruction of the session
//   imem_we/ready/addr/wdata  memory write port (held stable while stalled)
//   busy, done, err, err_code, count  session status
module instr_encoder #(
  parameter int unsigned AW        = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_mnem,
  input  logic [2:0]    in_ra,
  input  logic [2:0]    in_rb,
  input  logic [2:0]    in_rc,
  input  logic [AW-1:0] in_imm,
  input  logic          in_last,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [15:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] AddrBase = AW'(BASE_ADDR);
  localparam logic [AW-1:0] AddrOne  = AW'(1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StDone, StErr} state_e;

  state_e        r_state, w_state_next;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [15:0]   r_wdata;
  logic [AW:0]   r_count;
  logic [1:0]    r_err_code;

  logic [15:0]   w_word;
  logic          w_legal, w_range_ok, w_ok;
  logic [11:0]   w_imm_ext;
  logic          w_imm_fits;
  logic [13:0]   w_off;
  logic          w_off_ok;
  logic          w_accept;
  logic          w_at_top;

  // Encoder
  assign w_imm_ext  = 12'(in_imm);
  assign w_imm_fits = (w_imm_ext <= 12'd63);
  // Offset relative to the instruction after this one; wide enough that no AW<=12 wraps
  assign w_off      = 14'(in_imm) - 14'(r_addr) - 14'd1;
  assign w_off_ok   = ($signed(w_off) >= -14'sd32) && ($signed(w_off) <= 14'sd31);

  always_comb begin
    w_word     = '0;
    w_legal    = 1'b1;
    w_range_ok = 1'b1;
    case (in_mnem)
      5'd0:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b000}; // ADD
      5'd1:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b010}; // SUB
      5'd2:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b100}; // AND
      5'd3:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b101}; // ORR
      5'd4:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b001}; // MOV
      5'd5:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b011}; // EOR
      5'd6:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b110}; // BIC
      5'd7:  w_word = {4'b0000, in_ra, in_rb, in_rc, 3'b111}; // MVN
      5'd8:  begin w_word = {4'b0100, in_ra, in_rb, w_imm_ext[5:0]}; w_range_ok = w_imm_fits; end
      5'd9:  begin w_word = {4'b0101, in_ra, in_rb, w_imm_ext[5:0]}; w_range_ok = w_imm_fits; end
      5'd10: begin w_word = {4'b0001, in_ra, 3'b000, w_imm_ext[5:0]}; w_range_ok = w_imm_fits; end
      5'd11: begin w_word = {4'b1011, in_ra, in_rb, w_imm_ext[5:0]}; w_range_ok = w_imm_fits; end
      5'd12: begin w_word = {4'b1111, in_ra, in_rb, w_imm_ext[5:0]}; w_range_ok = w_imm_fits; end
      5'd13: begin w_word = {4'b1000, in_ra, in_rb, w_off[5:0]}; w_range_ok = w_off_ok; end
      5'd14: begin w_word = {4'b1001, in_ra, in_rb, w_off[5:0]}; w_range_ok = w_off_ok; end
      5'd15: begin w_word = {4'b1010, in_ra, in_rb, w_off[5:0]}; w_range_ok = w_off_ok; end
      5'd16: begin w_word = {4'b1100, in_ra, in_rb, w_off[5:0]}; w_range_ok = w_off_ok; end
      5'd17: begin w_word = {4'b1101, in_ra, in_rb, w_off[5:0]}; w_range_ok = w_off_ok; end
      5'd18: begin w_word = {4'b1110, in_ra, in_rb, w_off[5:0]}; w_range_ok = w_off_ok; end
      5'd19: w_word = {4'b0010, w_imm_ext};                    // J
      default: w_legal = 1'b0;
    endcase
  end

  assign w_ok     = w_legal && w_range_ok;
  assign w_accept = in_valid && in_ready;
  assign w_at_top = (r_addr == {AW{1'b1}});

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = StLoad;
    end else begin
      case (r_state)
        StLoad: begin
          if (w_accept) begin
            if (!w_ok)         w_state_next = StErr;
            else if (in_last)  w_state_next = StDrain;
            else if (w_at_top) w_state_next = StErr;
          end
        end
        StDrain: if (r_we && imem_ready) w_state_next = StDone;
        default: ;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    // New word may enter only when the output register is empty or draining this cycle
    in_ready = (r_state == StLoad) && !start && (!r_we || imem_ready);
    busy     = (r_state == StLoad) || (r_state == StDrain);
    done     = (r_state == StDone);
    err      = (r_state == StErr);
  end

  // Datapath: address counter, output register, write count, error code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= AddrBase;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_count    <= '0;
      r_err_code <= '0;
    end else if (start) begin
      r_addr     <= AddrBase;
      r_we       <= 1'b0;
      r_count    <= '0;
      r_err_code <= '0;
    end else begin
      if (r_we && imem_ready) begin
        r_we    <= 1'b0;
        r_count <= r_count + CntOne;
      end
      if (w_accept) begin
        if (!w_ok) begin
          r_err_code <= w_legal ? 2'd1 : 2'd0;
        end else begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          r_wdata <= w_word;
          r_addr  <= r_addr + AddrOne;
          if (!in_last && w_at_top) r_err_code <= 2'd2;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign err_code   = r_err_code;
  assign count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_last, imem_ready;
  logic [4:0]  in_mnem;
  logic [2:0]  in_ra, in_rb, in_rc;
  logic [7:0]  in_imm;
  logic        in_ready, imem_we, busy, done, err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [1:0]  err_code;
  logic [8:0]  count;

  // Small instance (AW=3) for address-overflow checks
  logic        s_start, s_valid;
  logic [2:0]  s_imm;
  logic        s_in_ready, s_imem_we, s_busy, s_done, s_err;
  logic [2:0]  s_imem_addr;
  logic [15:0] s_imem_wdata;
  logic [1:0]  s_err_code;
  logic [3:0]  s_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(8), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .count(count)
  );

  instr_encoder #(.AW(3), .BASE_ADDR(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_mnem(in_mnem), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_imm(s_imm),
    .in_last(in_last), .imem_we(s_imem_we), .imem_ready(imem_ready), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .busy(s_busy), .done(s_done), .err(s_err),
    .err_code(s_err_code), .count(s_count)
  );

  task automatic set_in(input logic [4:0] m, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] c, input logic [7:0] imm, input logic last,
                        input logic v);
    in_mnem = m; in_ra = a; in_rb = b; in_rc = c; in_imm = imm; in_last = last; in_valid = v;
  endtask

  // Pulse start for one cycle; returns at the next falling edge with the session in LOAD
  task automatic pulse_start();
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imem_ready = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_imm = '0;
    set_in(5'd0, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    if ({imem_we, in_ready, busy, done, err} !== 5'b0) begin n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {imem_we, in_ready, busy, done, err}); end
    n_vec++;
    if (count !== 9'd0 || err_code !== 2'd0) begin n_bad++;
      $display("FAIL reset_cnt: got count=%0d code=%0d want 0/0", count, err_code); end
    n_vec++;
    if (imem_addr !== 8'd0 || imem_wdata !== 16'h0) begin n_bad++;
      $display("FAIL reset_out: got addr=%h wdata=%h want 0/0", imem_addr, imem_wdata); end
    n_vec++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    pulse_start();
    set_in(5'd0, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0, 1'b1); imem_ready = 1'b1;
    #1;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL add_ready: got rdy=%b busy=%b want 1/1", in_ready, busy); end
    n_vec++;
    @(negedge clk); in_valid = 1'b0; #1;
    if (imem_we !== 1'b1 || imem_addr !== 8'd0 || imem_wdata !== 16'h0298) begin n_bad++;
      $display("FAIL add_write: got we=%b addr=%h wdata=%h want 1/00/0298",
               imem_we, imem_addr, imem_wdata); end
    n_vec++;
    @(negedge clk); #1;
    if (count !== 9'd1 || imem_we !== 1'b0) begin n_bad++;
      $display("FAIL add_count: got count=%0d we=%b want 1/0", count, imem_we); end
    n_vec++;
  endtask

  task automatic test_back_to_back_branch();
    @(negedge clk); set_in(5'd8, 3'd1, 3'd1, 3'd0, 8'd5, 1'b0, 1'b1);
    @(negedge clk); set_in(5'd13, 3'd1, 3'd2, 3'd0, 8'd0, 1'b1, 1'b1); #1;
    if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 16'h4245 || in_ready !== 1'b1)
    begin n_bad++;
      $display("FAIL addi_write: got we=%b addr=%h wdata=%h rdy=%b want 1/01/4245/1",
               imem_we, imem_addr, imem_wdata, in_ready); end
    n_vec++;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;
    if (imem_we !== 1'b1 || imem_addr !== 8'd2 || imem_wdata !== 16'h82BD || in_ready !== 1'b0)
    begin n_bad++;
      $display("FAIL beq_write: got we=%b addr=%h wdata=%h rdy=%b want 1/02/82bd/0",
               imem_we, imem_addr, imem_wdata, in_ready); end
    n_vec++;
    @(negedge clk); #1;
    if (done !== 1'b1 || busy !== 1'b0 || count !== 9'd3) begin n_bad++;
      $display("FAIL beq_done: got done=%b busy=%b count=%0d want 1/0/3", done, busy, count); end
    n_vec++;
  endtask

  task automatic test_stall();
    pulse_start();
    imem_ready = 1'b0;
    set_in(5'd7, 3'd7, 3'd0, 3'd5, 8'd0, 1'b0, 1'b1); #1;
    if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL stall_first_rdy: got %b want 1", in_ready); end
    n_vec++;
    @(negedge clk); set_in(5'd19, 3'd0, 3'd0, 3'd0, 8'h10, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 8'd0 ||
          imem_wdata !== 16'h0E2F) begin n_bad++;
        $display("FAIL stall_hold%0d: got rdy=%b we=%b addr=%h wdata=%h want 0/1/00/0e2f",
                 k, in_ready, imem_we, imem_addr, imem_wdata); end
      n_vec++;
      @(negedge clk);
    end
    imem_ready = 1'b1; #1;
    if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL stall_release_rdy: got %b want 1", in_ready); end
    n_vec++;
    @(negedge clk); in_valid = 1'b0; #1;
    if (imem_we !== 1'b1 || imem_addr !== 8'd1 || imem_wdata !== 16'h2010) begin n_bad++;
      $display("FAIL j_write: got we=%b addr=%h wdata=%h want 1/01/2010",
               imem_we, imem_addr, imem_wdata); end
    n_vec++;
    @(negedge clk); #1;
    if (count !== 9'd2) begin n_bad++;
      $display("FAIL stall_count: got %0d want 2", count); end
    n_vec++;
  endtask

  task automatic test_err_range();
    // Offer an ADD during the start cycle: it must not be taken
    @(negedge clk); start = 1'b1; set_in(5'd0, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0, 1'b1); #1;
    if (in_ready !== 1'b0) begin n_bad++;
      $display("FAIL start_cycle_rdy: got %b want 0", in_ready); end
    n_vec++;
    @(negedge clk); start = 1'b0; set_in(5'd8, 3'd1, 3'd1, 3'd0, 8'd64, 1'b0, 1'b1); #1;
    if (in_ready !== 1'b1 || imem_we !== 1'b0) begin n_bad++;
      $display("FAIL start_no_accept: got rdy=%b we=%b want 1/0", in_ready, imem_we); end
    n_vec++;
    @(negedge clk); #1;
    if (err !== 1'b1 || err_code !== 2'd1 || imem_we !== 1'b0 || in_ready !== 1'b0) begin n_bad++;
      $display("FAIL imm_range: got err=%b code=%0d we=%b rdy=%b want 1/1/0/0",
               err, err_code, imem_we, in_ready); end
    n_vec++;
    @(negedge clk); #1;
    if (in_ready !== 1'b0 || count !== 9'd0 || imem_we !== 1'b0) begin n_bad++;
      $display("FAIL err_hold: got rdy=%b count=%0d we=%b want 0/0/0", in_ready, count, imem_we);
    end
    n_vec++;
    pulse_start(); #1;
    if (err !== 1'b0 || busy !== 1'b1) begin n_bad++;
      $display("FAIL err_restart: got err=%b busy=%b want 0/1", err, busy); end
    n_vec++;
    set_in(5'd0, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0; #1;
    if (imem_addr !== 8'd0 || imem_wdata !== 16'h0298 || imem_we !== 1'b1) begin n_bad++;
      $display("FAIL restart_addr: got addr=%h wdata=%h we=%b want 00/0298/1",
               imem_addr, imem_wdata, imem_we); end
    n_vec++;
  endtask

  task automatic test_illegal_and_offsets();
    pulse_start();
    set_in(5'd25, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0; #1;
    if (err !== 1'b1 || err_code !== 2'd0 || imem_we !== 1'b0) begin n_bad++;
      $display("FAIL illegal_mnem: got err=%b code=%0d we=%b want 1/0/0", err, err_code, imem_we);
    end
    n_vec++;
    pulse_start();
    set_in(5'd16, 3'd1, 3'd2, 3'd0, 8'd40, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0; #1;
    if (err !== 1'b1 || err_code !== 2'd1) begin n_bad++;
      $display("FAIL blt_range: got err=%b code=%0d want 1/1", err, err_code); end
    n_vec++;
    // Offset +31 (upper limit) and MOVI imm 63 with rb forced to 0
    pulse_start();
    set_in(5'd17, 3'd0, 3'd0, 3'd0, 8'd32, 1'b0, 1'b1);
    @(negedge clk); set_in(5'd10, 3'd2, 3'd5, 3'd0, 8'd63, 1'b1, 1'b1); #1;
    if (imem_addr !== 8'd0 || imem_wdata !== 16'hD01F || err !== 1'b0) begin n_bad++;
      $display("FAIL bge_max_off: got addr=%h wdata=%h err=%b want 00/d01f/0",
               imem_addr, imem_wdata, err); end
    n_vec++;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; #1;
    if (imem_addr !== 8'd1 || imem_wdata !== 16'h143F) begin n_bad++;
      $display("FAIL movi_write: got addr=%h wdata=%h want 01/143f", imem_addr, imem_wdata); end
    n_vec++;
    @(negedge clk); #1;
    if (done !== 1'b1 || count !== 9'd2) begin n_bad++;
      $display("FAIL movi_done: got done=%b count=%0d want 1/2", done, count); end
    n_vec++;
  endtask

  task automatic test_overflow();
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0; imem_ready = 1'b1;
    set_in(5'd0, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0, 1'b0);
    s_imm = '0; s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (i < 8) begin
        if (s_in_ready !== 1'b1) begin n_bad++;
          $display("FAIL ovf_rdy%0d: got %b want 1", i, s_in_ready); end
        n_vec++;
      end else begin
        if (s_in_ready !== 1'b0 || s_err !== 1'b1 || s_err_code !== 2'd2) begin n_bad++;
          $display("FAIL ovf_err: got rdy=%b err=%b code=%0d want 0/1/2",
                   s_in_ready, s_err, s_err_code); end
        n_vec++;
      end
      if (i > 0) begin
        if (s_imem_we !== 1'b1 || s_imem_addr !== 3'(i - 1)) begin n_bad++;
          $display("FAIL ovf_write%0d: got we=%b addr=%0d want 1/%0d",
                   i, s_imem_we, s_imem_addr, i - 1); end
        n_vec++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; #1;
    if (s_imem_we !== 1'b0 || s_count !== 4'd8 || s_err !== 1'b1) begin n_bad++;
      $display("FAIL ovf_count: got we=%b count=%0d err=%b want 0/8/1",
               s_imem_we, s_count, s_err); end
    n_vec++;
  endtask

  task automatic test_reset_mid_stall();
    pulse_start();
    imem_ready = 1'b0;
    set_in(5'd0, 3'd1, 3'd2, 3'd3, 8'd0, 1'b0, 1'b1);
    @(negedge clk); in_valid = 1'b0; #1;
    if (imem_we !== 1'b1) begin n_bad++;
      $display("FAIL midrst_pending: got we=%b want 1", imem_we); end
    n_vec++;
    #1 rst_n = 1'b0;
    #1;
    if (imem_we !== 1'b0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL midrst_abandon: got we=%b busy=%b want 0/0", imem_we, busy); end
    n_vec++;
    @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back_branch();
    test_stall();
    test_err_range();
    test_illegal_and_offsets();
    test_overflow();
    test_reset_mid_stall();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
